// File: rtl/uart_rx_pkg.sv
// Shared types, sizes and helpers for the UART receive front end.
package uart_rx_pkg;

  localparam int PRESCALE_W   = 6;
  localparam int DATA_BITS    = 8;
  localparam int BIT_IDX_W    = 4;
  localparam int MIN_PRESCALE = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_e;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sync2.sv
// Two-flop synchronizer for the asynchronous serial line; both stages reset to the idle level.
module uart_rx_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  logic meta;

  // Synchronizer stages
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b1;
      dout <= 1'b1;
    end else begin
      meta <= din;
      dout <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_bit_sampler.sv
// UART receive front end: start detection, oversampled bit tracking and
// 2-of-3 midpoint voting, with per-bit strobes and start/stop error status.
module uart_rx_bit_sampler #(
  parameter int PRESCALE_W = uart_rx_pkg::PRESCALE_W,
  parameter int DATA_BITS  = uart_rx_pkg::DATA_BITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_in,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  sampled_bit,
  output logic                  bit_valid,
  output logic [3:0]            bit_idx,
  output logic                  deser_en,
  output logic                  start_glitch,
  output logic                  frame_done,
  output logic                  stop_err
);

  import uart_rx_pkg::*;

  logic                  rx_s;
  rx_state_e             state, state_next;
  logic [PRESCALE_W-1:0] edge_cnt, edge_next, ps_q, ps_next, mid;
  logic [BIT_IDX_W-1:0]  bit_cnt, bit_next, bit_idx_next;
  logic                  samp_lo, samp_lo_next, samp_mid, samp_mid_next;
  logic                  armed, armed_next;
  logic                  at_vote, at_end, vote;
  logic                  sampled_next, bit_valid_next, glitch_next;
  logic                  done_next, stop_err_next, deser_next;

  uart_rx_sync2 u_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (rx_in),
    .dout (rx_s)
  );

  assign mid     = {1'b0, ps_q[PRESCALE_W-1:1]};
  assign at_vote = (edge_cnt == (mid + PRESCALE_W'(1)));
  assign at_end  = (edge_cnt == (ps_q - PRESCALE_W'(1)));
  assign vote    = majority3(samp_lo, samp_mid, rx_s);

  // State, counters, samples and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      edge_cnt     <= PRESCALE_W'(0);
      bit_cnt      <= BIT_IDX_W'(0);
      ps_q         <= PRESCALE_W'(0);
      samp_lo      <= 1'b1;
      samp_mid     <= 1'b1;
      armed        <= 1'b0;
      sampled_bit  <= 1'b1;
      bit_valid    <= 1'b0;
      bit_idx      <= 4'd0;
      deser_en     <= 1'b0;
      start_glitch <= 1'b0;
      frame_done   <= 1'b0;
      stop_err     <= 1'b0;
    end else begin
      state        <= state_next;
      edge_cnt     <= edge_next;
      bit_cnt      <= bit_next;
      ps_q         <= ps_next;
      samp_lo      <= samp_lo_next;
      samp_mid     <= samp_mid_next;
      armed        <= armed_next;
      sampled_bit  <= sampled_next;
      bit_valid    <= bit_valid_next;
      bit_idx      <= bit_idx_next;
      deser_en     <= deser_next;
      start_glitch <= glitch_next;
      frame_done   <= done_next;
      stop_err     <= stop_err_next;
    end
  end

  // Next state, edge/bit counters and sample capture
  always_comb begin
    state_next    = state;
    edge_next     = edge_cnt;
    bit_next      = bit_cnt;
    ps_next       = ps_q;
    armed_next    = armed;
    samp_lo_next  = samp_lo;
    samp_mid_next = samp_mid;
    if ((state != ST_IDLE) && (edge_cnt == (mid - PRESCALE_W'(1)))) begin
      samp_lo_next = rx_s;
    end else begin
      samp_lo_next = samp_lo;
    end
    if ((state != ST_IDLE) && (edge_cnt == mid)) begin
      samp_mid_next = rx_s;
    end else begin
      samp_mid_next = samp_mid;
    end
    case (state)
      ST_IDLE: begin
        edge_next = PRESCALE_W'(0);
        bit_next  = BIT_IDX_W'(0);
        // armed blocks a restart while the line is still low after a framing error
        if (!rx_s && armed && (prescale >= PRESCALE_W'(MIN_PRESCALE))) begin
          state_next = ST_START;
          ps_next    = prescale;
        end else begin
          armed_next = armed | rx_s;
        end
      end
      ST_START: begin
        if (at_vote && vote) begin
          state_next = ST_IDLE;
          edge_next  = PRESCALE_W'(0);
        end else if (at_end) begin
          state_next = ST_DATA;
          edge_next  = PRESCALE_W'(0);
          bit_next   = BIT_IDX_W'(0);
        end else begin
          edge_next = edge_cnt + PRESCALE_W'(1);
        end
      end
      ST_DATA: begin
        if (at_end) begin
          edge_next = PRESCALE_W'(0);
          if (bit_cnt == BIT_IDX_W'(DATA_BITS - 1)) begin
            state_next = ST_STOP;
            bit_next   = BIT_IDX_W'(0);
          end else begin
            bit_next = bit_cnt + BIT_IDX_W'(1);
          end
        end else begin
          edge_next = edge_cnt + PRESCALE_W'(1);
        end
      end
      ST_STOP: begin
        if (at_vote) begin
          state_next = ST_IDLE;
          edge_next  = PRESCALE_W'(0);
          armed_next = vote;
        end else begin
          edge_next = edge_cnt + PRESCALE_W'(1);
        end
      end
      default: begin
        state_next = ST_IDLE;
        edge_next  = PRESCALE_W'(0);
        bit_next   = BIT_IDX_W'(0);
      end
    endcase
  end

  // Output values registered on the next edge
  always_comb begin
    sampled_next   = sampled_bit;
    bit_valid_next = 1'b0;
    bit_idx_next   = bit_idx;
    glitch_next    = 1'b0;
    done_next      = 1'b0;
    stop_err_next  = stop_err;
    deser_next     = (state_next == ST_DATA);
    case (state)
      ST_START: begin
        if (at_vote && vote) begin
          glitch_next = 1'b1;
        end else begin
          glitch_next = 1'b0;
        end
      end
      ST_DATA: begin
        if (at_vote) begin
          sampled_next   = vote;
          bit_valid_next = 1'b1;
          bit_idx_next   = bit_cnt;
        end else begin
          bit_valid_next = 1'b0;
        end
      end
      ST_STOP: begin
        if (at_vote) begin
          sampled_next   = vote;
          bit_valid_next = 1'b1;
          done_next      = 1'b1;
          stop_err_next  = ~vote;
        end else begin
          done_next = 1'b0;
        end
      end
      default: begin
        glitch_next = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_rx_bit_sampler.sv
// Self-checking bench: per-cycle line waveforms checked against a frame-level reference model.
module tb_uart_rx_bit_sampler;

  localparam int PW   = 6;
  localparam int MAXN = 8192;
  localparam int TAIL = 800;

  logic          clk = 1'b0;
  logic          rst;
  logic          rx_in;
  logic [PW-1:0] prescale;
  logic          sampled_bit, bit_valid, deser_en, start_glitch, frame_done, stop_err;
  logic [3:0]    bit_idx;

  uart_rx_bit_sampler dut (
    .clk          (clk),
    .rst          (rst),
    .rx_in        (rx_in),
    .prescale     (prescale),
    .sampled_bit  (sampled_bit),
    .bit_valid    (bit_valid),
    .bit_idx      (bit_idx),
    .deser_en     (deser_en),
    .start_glitch (start_glitch),
    .frame_done   (frame_done),
    .stop_err     (stop_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int t;
    bit glitch;
    bit valid;
    bit sb;
    int idx;
    bit done;
    bit err;
  } ev_t;

  ev_t  dut_q[$];
  ev_t  exp_q[$];
  logic line_arr [0:MAXN-1];
  int   pre_arr  [0:MAXN-1];
  int   n_len;
  int   cur_pre;
  int   checks = 0;
  int   errors = 0;
  int   dut_deser, exp_deser, got_glitches;
  logic [7:0] shreg;
  logic [7:0] got_bytes[$];
  bit   got_errs[$];
  int   strobe_t[$];

  initial begin
    #5000000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1, "timeout");
  end

  function automatic logic line_at(input int i);
    return (i < n_len) ? line_arr[i] : 1'b1;
  endfunction

  function automatic int pre_at(input int i);
    return (i < n_len) ? pre_arr[i] : pre_arr[n_len-1];
  endfunction

  // 2-of-3 vote over three consecutive line cycles
  function automatic bit vote_at(input int base);
    int n = 0;
    for (int k = 0; k < 3; k++) n += line_at(base + k) ? 1 : 0;
    return (n >= 2);
  endfunction

  task automatic add_level(input logic v, input int n);
    for (int k = 0; k < n; k++) begin
      line_arr[n_len] = v;
      pre_arr[n_len]  = cur_pre;
      n_len++;
    end
  endtask

  task automatic add_frame(input logic [7:0] d, input int ps, input logic stopv);
    add_level(1'b0, ps);
    for (int i = 0; i < 8; i++) add_level(d[i], ps);
    add_level(stopv, ps);
  endtask

  task automatic push_exp(input int t, input bit g, input bit v, input bit sb,
                          input int idx, input bit d, input bit e);
    ev_t x;
    x.t = t; x.glitch = g; x.valid = v; x.sb = sb; x.idx = idx; x.done = d; x.err = e;
    exp_q.push_back(x);
  endtask

  // Frame-level model: bit b of a frame whose line falls at f is voted over
  // line[f+b*ps+mid .. +2]; its strobe appears after clock f+b*ps+mid+4.
  task automatic build_expected();
    int pos, f, ps, mid;
    bit armed, v;
    exp_q.delete();
    exp_deser = 0;
    pos = 0;
    armed = 1'b1;
    while (pos < n_len) begin
      if (line_at(pos) == 1'b0 && armed && pre_at(pos + 2) >= 4) begin
        f = pos;
        ps = pre_at(pos + 2);
        mid = ps / 2;
        if (vote_at(f + mid)) begin
          push_exp(f + mid + 4, 1'b1, 1'b0, 1'b0, -1, 1'b0, 1'b0);
          pos = f + mid + 3;
        end else begin
          for (int b = 1; b <= 8; b++)
            push_exp(f + b*ps + mid + 4, 1'b0, 1'b1, vote_at(f + b*ps + mid), b - 1, 1'b0, 1'b0);
          v = vote_at(f + 9*ps + mid);
          push_exp(f + 9*ps + mid + 4, 1'b0, 1'b1, v, -1, 1'b1, !v);
          exp_deser += 8 * ps;
          if (!v) armed = 1'b0;
          pos = f + 9*ps + mid + 3;
        end
      end else begin
        if (line_at(pos)) armed = 1'b1;
        pos++;
      end
    end
  endtask

  task automatic record(input int t);
    ev_t x;
    if (deser_en) dut_deser++;
    if (start_glitch) got_glitches++;
    if (bit_valid || start_glitch) begin
      x.t = t; x.glitch = start_glitch; x.valid = bit_valid; x.sb = sampled_bit;
      x.idx = int'(bit_idx); x.done = frame_done; x.err = stop_err;
      dut_q.push_back(x);
    end
    if (bit_valid && !frame_done) begin
      shreg = {sampled_bit, shreg[7:1]};
      strobe_t.push_back(t);
    end
    if (frame_done) begin
      got_bytes.push_back(shreg);
      got_errs.push_back(stop_err);
    end
  endtask

  task automatic run_scenario();
    dut_q.delete(); got_bytes.delete(); got_errs.delete(); strobe_t.delete();
    got_glitches = 0;
    dut_deser = 0;
    shreg = 8'h00;
    for (int c = 0; c < n_len + TAIL; c++) begin
      @(negedge clk);
      if (c > 0) record(c - 1);
      rx_in = line_at(c);
      prescale = PW'(pre_at(c));
    end
    @(negedge clk);
    record(n_len + TAIL - 1);
  endtask

  task automatic compare_model(input string name);
    ev_t a, e;
    bit ok;
    build_expected();
    checks++;
    if (dut_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL %s event_count got %0d expected %0d", name, dut_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < dut_q.size(); i++) begin
      a = dut_q[i];
      e = exp_q[i];
      ok = (a.t == e.t) && (a.glitch == e.glitch) && (a.valid == e.valid) && (a.done == e.done)
           && (e.glitch || a.sb == e.sb) && (!e.done || a.err == e.err) && (e.idx < 0 || a.idx == e.idx);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL %s event[%0d] got t=%0d g=%0b v=%0b b=%0b idx=%0d d=%0b e=%0b expected t=%0d g=%0b v=%0b b=%0b idx=%0d d=%0b e=%0b",
                 name, i, a.t, a.glitch, a.valid, a.sb, a.idx, a.done, a.err,
                 e.t, e.glitch, e.valid, e.sb, e.idx, e.done, e.err);
      end
    end
    checks++;
    if (dut_deser != exp_deser) begin
      errors++;
      $display("FAIL %s deser_cycles got %0d expected %0d", name, dut_deser, exp_deser);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; rx_in = 1'b1; prescale = PW'(8);
    repeat (3) @(negedge clk);
    checks++;
    if ({sampled_bit, bit_valid, bit_idx, deser_en, start_glitch, frame_done, stop_err} !== 10'b1000000000) begin
      errors++;
      $display("FAIL reset_outputs got %b expected %b",
               {sampled_bit, bit_valid, bit_idx, deser_en, start_glitch, frame_done, stop_err}, 10'b1000000000);
    end
    rst = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_clean_frame();
    bit sp_ok;
    n_len = 0; cur_pre = 8;
    add_level(1'b1, 6);
    add_frame(8'hA5, 8, 1'b1);
    add_level(1'b1, 10);
    run_scenario();
    compare_model("clean");
    checks++;
    if (got_bytes.size() != 1 || got_bytes[0] !== 8'hA5 || got_errs[0] !== 1'b0) begin
      errors++;
      $display("FAIL clean_byte got %0d bytes first=%h err=%0b expected 1 byte a5 err=0",
               got_bytes.size(), got_bytes[0], got_errs[0]);
    end
    sp_ok = (strobe_t.size() == 8);
    for (int i = 1; i < strobe_t.size(); i++) if (strobe_t[i] - strobe_t[i-1] != 8) sp_ok = 1'b0;
    checks++;
    if (!sp_ok) begin
      errors++;
      $display("FAIL clean_spacing got %0d strobes expected 8 spaced by 8", strobe_t.size());
    end
    checks++;
    if (dut_deser != 64) begin
      errors++;
      $display("FAIL clean_deser got %0d expected 64", dut_deser);
    end
  endtask

  task automatic test_start_glitch();
    n_len = 0; cur_pre = 16;
    add_level(1'b1, 6);
    add_level(1'b0, 3);
    add_level(1'b1, 40);
    add_frame(8'h3C, 16, 1'b1);
    add_level(1'b1, 10);
    run_scenario();
    compare_model("glitch");
    checks++;
    if (got_glitches != 1 || got_bytes.size() != 1 || got_bytes[0] !== 8'h3C) begin
      errors++;
      $display("FAIL glitch_result got glitches=%0d bytes=%0d first=%h expected 1 1 3c",
               got_glitches, got_bytes.size(), got_bytes[0]);
    end
  endtask

  task automatic test_noisy_vote();
    int f;
    n_len = 0; cur_pre = 16;
    add_level(1'b1, 6);
    f = n_len;
    add_frame(8'hFF, 16, 1'b1);
    for (int b = 1; b <= 8; b++) line_arr[f + b*16 + 9] = ~line_arr[f + b*16 + 9];
    add_level(1'b1, 20);
    f = n_len;
    add_frame(8'hFF, 16, 1'b1);
    line_arr[f + 4*16 + 9]  = 1'b0;
    line_arr[f + 4*16 + 10] = 1'b0;
    add_level(1'b1, 10);
    run_scenario();
    compare_model("noisy");
    checks++;
    if (got_bytes.size() != 2 || got_bytes[0] !== 8'hFF || got_bytes[1] !== 8'hF7) begin
      errors++;
      $display("FAIL noisy_bytes got n=%0d %h %h expected 2 ff f7",
               got_bytes.size(), got_bytes[0], got_bytes[1]);
    end
  endtask

  task automatic test_framing_error();
    n_len = 0; cur_pre = 8;
    add_level(1'b1, 6);
    add_frame(8'h55, 8, 1'b0);
    add_level(1'b0, 30);
    add_level(1'b1, 20);
    add_frame(8'h81, 8, 1'b1);
    add_level(1'b1, 10);
    run_scenario();
    compare_model("framing");
    checks++;
    if (got_errs.size() != 2 || got_errs[0] !== 1'b1 || got_errs[1] !== 1'b0 ||
        got_bytes[0] !== 8'h55 || got_bytes[1] !== 8'h81) begin
      errors++;
      $display("FAIL framing_result got n=%0d err=%0b,%0b bytes=%h,%h expected 2 err=1,0 bytes=55,81",
               got_errs.size(), got_errs[0], got_errs[1], got_bytes[0], got_bytes[1]);
    end
  endtask

  task automatic test_back_to_back();
    int f;
    n_len = 0; cur_pre = 16;
    add_level(1'b1, 4);
    f = n_len;
    add_frame(8'h00, 16, 1'b1);
    add_frame(8'hFF, 8, 1'b1);
    add_level(1'b1, 10);
    for (int i = f + 40; i < n_len; i++) pre_arr[i] = 8;
    run_scenario();
    compare_model("b2b");
    checks++;
    if (got_bytes.size() != 2 || got_bytes[0] !== 8'h00 || got_bytes[1] !== 8'hFF ||
        got_errs[0] !== 1'b0 || got_errs[1] !== 1'b0 || dut_deser != 192) begin
      errors++;
      $display("FAIL b2b_result got n=%0d bytes=%h,%h deser=%0d expected 2 bytes=00,ff deser=192",
               got_bytes.size(), got_bytes[0], got_bytes[1], dut_deser);
    end
  endtask

  task automatic test_midframe_reset();
    int act;
    prescale = PW'(8);
    rx_in = 1'b1;
    repeat (5) @(negedge clk);
    for (int c = 0; c < 44; c++) begin
      @(negedge clk);
      rx_in = 1'b0;
    end
    @(negedge clk);
    checks++;
    if (deser_en !== 1'b1) begin
      errors++;
      $display("FAIL reset_pre_deser got %0b expected 1", deser_en);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({sampled_bit, bit_valid, bit_idx, deser_en, start_glitch, frame_done, stop_err} !== 10'b1000000000) begin
      errors++;
      $display("FAIL midframe_reset got %b expected %b",
               {sampled_bit, bit_valid, bit_idx, deser_en, start_glitch, frame_done, stop_err}, 10'b1000000000);
    end
    rst = 1'b0;
    rx_in = 1'b1;
    act = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (frame_done || bit_valid || start_glitch || deser_en) act++;
    end
    checks++;
    if (act != 0) begin
      errors++;
      $display("FAIL reset_no_done got %0d active cycles expected 0", act);
    end
  endtask

  task automatic test_illegal_prescale();
    int act;
    prescale = PW'(2);
    rx_in = 1'b1;
    repeat (5) @(negedge clk);
    rx_in = 1'b0;
    act = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (frame_done || bit_valid || start_glitch || deser_en) act++;
    end
    checks++;
    if (act != 0) begin
      errors++;
      $display("FAIL illegal_prescale got %0d active cycles expected 0", act);
    end
    rx_in = 1'b1;
    repeat (5) @(negedge clk);
    prescale = PW'(8);
    repeat (5) @(negedge clk);
  endtask

  task automatic test_random();
    int ps, idx;
    for (int r = 0; r < 3; r++) begin
      n_len = 0;
      for (int k = 0; k < 3; k++) begin
        ps = 8 + 2 * $urandom_range(0, 27);
        cur_pre = ps;
        add_level(1'b1, $urandom_range(1, 20));
        add_frame(8'($urandom), ps, ($urandom_range(0, 3) != 0));
      end
      add_level(1'b1, 5);
      for (int k = 0; k < 3; k++) begin
        idx = $urandom_range(0, n_len - 1);
        line_arr[idx] = ~line_arr[idx];
      end
      run_scenario();
      compare_model("random");
    end
  endtask

  initial begin
    rst = 1'b1;
    rx_in = 1'b1;
    prescale = PW'(8);
    test_reset();
    test_clean_frame();
    test_start_glitch();
    test_noisy_vote();
    test_framing_error();
    test_back_to_back();
    test_midframe_reset();
    test_illegal_prescale();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
